// File: rtl/inst_mem_pkg.sv
// Shared constants and address helpers for the instruction memory responder.
// Mirrors the define.v constants (ZeroWord, InstBus, InstMemNum, ...) for SV users.
package inst_mem_pkg;

  localparam int INST_ADDR_W       = 32;  // InstAddrBus
  localparam int INST_W            = 32;  // InstBus
  localparam int INST_MEM_NUM_LOG2 = 10;  // InstMemNumLog2
  localparam int INST_MEM_NUM      = 1 << INST_MEM_NUM_LOG2;  // InstMemNum

  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic READ_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;

  // A byte address is usable when word-aligned and inside the 2**depth_log2 word array.
  function automatic logic addr_legal(input logic [INST_ADDR_W-1:0] a,
                                      input int unsigned depth_log2);
    return (a[1:0] == 2'b00) && ((a >> (depth_log2 + 2)) == '0);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Word-addressed single-clock RAM: one synchronous read port, one write port.
// Read-before-write on a same-word collision; the array is never reset.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = INST_MEM_NUM_LOG2
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [INST_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [INST_W-1:0]     wr_data
);

  logic [INST_W-1:0] mem [1 << DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/inst_mem.sv
// Instruction-memory responder: fixed-latency, validity-tagged fetch responses
// with misaligned/out-of-range flagging and a loader write port.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = INST_MEM_NUM_LOG2,
  parameter int LATENCY    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] addr,
  input  logic                   wr_en,
  input  logic [INST_ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0]      wr_data,
  output logic [INST_W-1:0]      inst,
  output logic                   inst_valid,
  output logic                   addr_err
);

  logic              rd_legal;
  logic              wr_legal;
  logic              rd_req;
  logic              wr_req;
  logic              vld_p0;
  logic              err_p0;
  logic [INST_W-1:0] data_p0;
  logic              vld_out;
  logic              err_out;
  logic [INST_W-1:0] data_out;

  assign rd_legal = addr_legal(addr, DEPTH_LOG2);
  assign wr_legal = addr_legal(wr_addr, DEPTH_LOG2);

  // Illegal fetches never touch the array; loader writes are dropped while in reset.
  assign rd_req = (ce == READ_ENABLE) && rd_legal && (rst != RST_ENABLE);
  assign wr_req = (wr_en == WRITE_ENABLE) && wr_legal && (rst != RST_ENABLE);

  inst_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .rd_en  (rd_req),
    .rd_idx (addr[DEPTH_LOG2+1:2]),
    .rd_data(data_p0),
    .wr_en  (wr_req),
    .wr_idx (wr_addr[DEPTH_LOG2+1:2]),
    .wr_data(wr_data)
  );

  // ---- stage p0: request capture alongside the RAM read register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      err_p0 <= 1'b0;
    end else begin
      vld_p0 <= ce;
      err_p0 <= ce & ~rd_legal;
    end
  end

  generate
    if (LATENCY <= 1) begin : g_direct
      assign vld_out  = vld_p0;
      assign err_out  = err_p0;
      assign data_out = data_p0;
    end else begin : g_pipe
      logic              vld_pn  [LATENCY-1];
      logic              err_pn  [LATENCY-1];
      logic [INST_W-1:0] data_pn [LATENCY-1];

      // ---- stages p1..p(LATENCY-1): free-running response shift ----
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LATENCY - 1; k++) begin
            vld_pn[k] <= 1'b0;
            err_pn[k] <= 1'b0;
          end
        end else begin
          vld_pn[0] <= vld_p0;
          err_pn[0] <= err_p0;
          for (int k = 1; k < LATENCY - 1; k++) begin
            vld_pn[k] <= vld_pn[k-1];
            err_pn[k] <= err_pn[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        data_pn[0] <= data_p0;
        for (int k = 1; k < LATENCY - 1; k++) begin
          data_pn[k] <= data_pn[k-1];
        end
      end

      assign vld_out  = vld_pn[LATENCY-2];
      assign err_out  = err_pn[LATENCY-2];
      assign data_out = data_pn[LATENCY-2];
    end
  endgenerate

  // Data registers are not reset, so the word is only exposed for a valid, legal response.
  assign inst       = (vld_out && !err_out) ? data_out : ZERO_WORD;
  assign inst_valid = vld_out;
  assign addr_err   = vld_out & err_out;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: LATENCY=1 and LATENCY=3 instances share stimulus,
// a vector table drives fetch/load traffic, plus a hand-written mid-stream reset.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] inst1, inst3;
  logic        valid1, valid3;
  logic        err1, err3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_mem #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .inst(inst1), .inst_valid(valid1), .addr_err(err1)
  );

  inst_mem #(.DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .inst(inst3), .inst_valid(valid3), .addr_err(err3)
  );

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        exp_v;
    logic        exp_e;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic [31:0] a, input logic w,
                              input logic [31:0] wa, input logic [31:0] wd,
                              input logic ev, input logic ee, input logic [31:0] ei);
    vec_t v;
    v.ce = c; v.addr = a; v.wr_en = w; v.wr_addr = wa; v.wr_data = wd;
    v.exp_v = ev; v.exp_e = ee; v.exp_inst = ei;
    return v;
  endfunction

  function automatic vec_t wr(input logic [31:0] wa, input logic [31:0] wd);
    return mk(1'b0, 32'h0, 1'b1, wa, wd, 1'b0, 1'b0, 32'h0);
  endfunction

  function automatic vec_t rd(input logic [31:0] a, input logic [31:0] ei);
    return mk(1'b1, a, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, ei);
  endfunction

  function automatic vec_t rd_bad(input logic [31:0] a);
    return mk(1'b1, a, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
  endfunction

  function automatic vec_t bub();
    return mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] ai, input logic av,
                       input logic ae, input logic [31:0] ei, input logic ev,
                       input logic ee);
    n_vec++;
    if (ai !== ei || av !== ev || ae !== ee) begin
      n_bad++;
      $display("FAIL %s: got inst=%08h valid=%0b err=%0b, want inst=%08h valid=%0b err=%0b",
               name, ai, av, ae, ei, ev, ee);
    end
  endtask

  task automatic drive(input vec_t v);
    ce = v.ce; addr = v.addr; wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
  endtask

  initial begin
    vec_t b;
    b = bub();
    rst = 1'b1;
    drive(b);

    // Reset state, asynchronous, before any clock edge
    #1;
    check("reset_l1", inst1, valid1, err1, 32'h0, 1'b0, 1'b0);
    check("reset_l3", inst3, valid3, err3, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Load words 0..7
    for (int i = 0; i < 8; i++) vecs.push_back(wr(32'(4 * i), 32'h1000_0000 + 32'(i)));
    // Stream
    for (int i = 0; i < 8; i++) vecs.push_back(rd(32'(4 * i), 32'h1000_0000 + 32'(i)));
    // Misaligned and out-of-range
    vecs.push_back(rd_bad(32'h0000_0006));
    vecs.push_back(rd_bad(32'h0000_1000));
    vecs.push_back(rd(32'h0000_0018, 32'h1000_0006));
    // Bubble between valid fetches
    vecs.push_back(rd(32'h4, 32'h1000_0001));
    vecs.push_back(bub());
    vecs.push_back(rd(32'h8, 32'h1000_0002));
    // Read/write collision on word 5
    vecs.push_back(wr(32'd20, 32'hA5A5_A5A5));
    vecs.push_back(mk(1'b1, 32'd20, 1'b1, 32'd20, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'hA5A5_A5A5));
    vecs.push_back(rd(32'd20, 32'h5A5A_5A5A));
    vecs.push_back(wr(32'd20, 32'h1000_0005));
    // Illegal writes: misaligned and out-of-range both alias word 0 if unchecked
    vecs.push_back(wr(32'h0000_0003, 32'hDEAD_BEEF));
    vecs.push_back(wr(32'h0000_1000, 32'hBAD0_BAD0));
    for (int i = 0; i < 8; i++) vecs.push_back(rd(32'(4 * i), 32'h1000_0000 + 32'(i)));

    for (int i = 0; i < vecs.size() + 2; i++) begin
      @(negedge clk);
      drive(i < vecs.size() ? vecs[i] : b);
      @(posedge clk);
      #1;
      if (i < vecs.size())
        check($sformatf("vec%0d_l1", i), inst1, valid1, err1,
              vecs[i].exp_inst, vecs[i].exp_v, vecs[i].exp_e);
      else
        check($sformatf("flush%0d_l1", i), inst1, valid1, err1, 32'h0, 1'b0, 1'b0);
      if (i >= 2)
        check($sformatf("vec%0d_l3", i - 2), inst3, valid3, err3,
              vecs[i-2].exp_inst, vecs[i-2].exp_v, vecs[i-2].exp_e);
      else
        check($sformatf("lead%0d_l3", i), inst3, valid3, err3, 32'h0, 1'b0, 1'b0);
    end

    // Mid-stream reset: three fetches in flight in the LATENCY=3 pipe
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(rd(32'(4 * k), 32'h0));
      @(posedge clk);
    end
    @(negedge clk);
    drive(b);
    check("pre_rst_l3", inst3, valid3, err3, 32'h1000_0000, 1'b1, 1'b0);
    check("pre_rst_l1", inst1, valid1, err1, 32'h1000_0002, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    ce = 1'b1; addr = 32'h4;
    wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'hFFFF_FFFF;
    #1;
    check("async_rst_l1", inst1, valid1, err1, 32'h0, 1'b0, 1'b0);
    check("async_rst_l3", inst3, valid3, err3, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("in_rst_l3", inst3, valid3, err3, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(rd(32'h0, 32'h0));
    @(posedge clk);
    #1;
    check("post_rst0_l1", inst1, valid1, err1, 32'h1000_0000, 1'b1, 1'b0);
    check("post_rst0_l3", inst3, valid3, err3, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(b);
    @(posedge clk);
    #1;
    check("post_rst1_l3", inst3, valid3, err3, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst2_l3", inst3, valid3, err3, 32'h1000_0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst3_l3", inst3, valid3, err3, 32'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
